// File: rtl/div32x32_seq_if.sv
// Handshake and result bundle for the sequential 32-bit divider.
// This bundle is shared by the controller (master) and the divider (slave).
interface div32x32_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, a, b,
    input  busy, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div32x32_seq.sv
// Radix-2 restoring 32/32 unsigned divider, one quotient bit per clock.
// Divide-by-zero and a < b finish early in one cycle.
module div32x32_seq (
  input  logic           clk,
  input  logic           reset,
  div32x32_seq_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] q_w_q, q_w_d;
  // Bit 32 of the working remainder is always zero because r < d holds, so it is not stored.
  logic [31:0] r_w_q, r_w_d;
  logic [31:0] d_w_q, d_w_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dbz_w_q, dbz_w_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        div_by_zero_q, div_by_zero_d;
  logic [32:0] t;

  always_comb begin
    state_d       = state_q;
    q_w_d         = q_w_q;
    r_w_d         = r_w_q;
    d_w_d         = d_w_q;
    cnt_d         = cnt_q;
    dbz_w_d       = dbz_w_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    t             = {r_w_q, q_w_q[31]};

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.b == 32'd0) begin
            q_w_d   = 32'hFFFF_FFFF;
            r_w_d   = bus.a;
            dbz_w_d = 1'b1;
            state_d = StDone;
          end else if (bus.a < bus.b) begin
            q_w_d   = 32'd0;
            r_w_d   = bus.a;
            dbz_w_d = 1'b0;
            state_d = StDone;
          end else begin
            q_w_d   = bus.a;
            r_w_d   = 32'd0;
            d_w_d   = bus.b;
            cnt_d   = 5'd0;
            dbz_w_d = 1'b0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (t >= {1'b0, d_w_q}) begin
          // Difference fits in 32 bits since it is below d.
          r_w_d = t[31:0] - d_w_q;
          q_w_d = {q_w_q[30:0], 1'b1};
        end else begin
          r_w_d = t[31:0];
          q_w_d = {q_w_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
        end
      end
      StDone: begin
        quotient_d    = q_w_q;
        remainder_d   = r_w_q;
        div_by_zero_d = dbz_w_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      q_w_q         <= 32'd0;
      r_w_q         <= 32'd0;
      d_w_q         <= 32'd0;
      cnt_q         <= 5'd0;
      dbz_w_q       <= 1'b0;
      quotient_q    <= 32'd0;
      remainder_q   <= 32'd0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      q_w_q         <= q_w_d;
      r_w_q         <= r_w_d;
      d_w_q         <= d_w_d;
      cnt_q         <= cnt_d;
      dbz_w_q       <= dbz_w_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: doc/div32x32_seq.md
# div32x32_seq

Sequential 32-bit unsigned divider: radix-2 restoring division, one quotient bit per clock, with a one-cycle early-out for divide-by-zero and dividend-less-than-divisor. It uses the same `start`/`busy` handshake as the 32x32 multiplier, so a system controller can drive either arithmetic unit identically. Results sit in dedicated output registers that change only on completion.

## Interface
- No parameters; widths fixed at 32.
- `clk`  input  1  clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high; forces IDLE and clears all registers.
- `start`  input  1  request a division; sampled only in IDLE.
- `a`  input  32  dividend, unsigned; sampled on the accepting edge only.
- `b`  input  32  divisor, unsigned; sampled on the accepting edge only.
- `busy`  output  1  low only in IDLE.
- `quotient`  output  32  registered result; holds last value between operations.
- `remainder`  output  32  registered result; holds last value between operations.
- `div_by_zero`  output  1  registered; set with results when `b` was 0, cleared by the next completed operation.

## Operation
- States: IDLE, CALC, DONE. `busy` = 0 in IDLE, 1 in CALC and DONE; decode is combinational from state.
- Working registers: `q_w[31:0]`, `r_w[32:0]`, `d_w[31:0]`, `cnt[4:0]`, plus staged `dbz_w`.
- IDLE, `start`=0: stay. IDLE, `start`=1, accepting edge:
  - `b`==0: `q_w`=0xFFFFFFFF, `r_w`={0,a}, `dbz_w`=1, next DONE.
  - else `a` < `b`: `q_w`=0, `r_w`={0,a}, `dbz_w`=0, next DONE.
  - else: `q_w`=a, `r_w`=0, `d_w`=b, `cnt`=0, `dbz_w`=0, next CALC.
  - The `b`==0 check takes precedence, so 0/0 reports divide-by-zero.
- CALC, per edge:
  - `t` = {`r_w`[31:0], `q_w`[31]} (33 bits).
  - If `t` >= {0,`d_w`}: `r_w` = `t` - `d_w`, `q_w` = {`q_w`[30:0],1}.
  - Else: `r_w` = `t`, `q_w` = {`q_w`[30:0],0}.
  - `cnt`++. When `cnt`==31 on this edge, next DONE; `cnt` wraps to 0.
- DONE, one edge:
  - `quotient` <= `q_w`, `remainder` <= `r_w`[31:0], `div_by_zero` <= `dbz_w`.
  - Next IDLE.
- `start` in CALC or DONE is ignored. It is not queued, and `a`/`b` changes have no effect.
- `start` held high in IDLE after completion launches a new operation on the first IDLE edge.
- Invariant: `r_w` < `d_w` after every CALC step, so `r_w`[32] is 0 at DONE.
- Reset, including mid-operation: state IDLE; `busy`=0; `quotient`, `remainder`, `div_by_zero`, all working registers = 0. The in-flight result is discarded.

## Timing
- Accepting edge E (IDLE, `start`=1). `busy` rises in the cycle after E.
- Normal path:
  - 32 CALC edges, E+1 through E+32, then the DONE edge at E+33.
  - `busy` is high for exactly 33 cycles.
  - Outputs change at E+33, coincident with `busy` falling.
- Early-out path: DONE edge at E+1; `busy` high for exactly 1 cycle; outputs change at E+1.
- Outputs are valid whenever `busy`=0. They are stable throughout `busy`=1 and show the previous result.
- Earliest back-to-back launch: edge E+34 on the normal path, E+2 on the early-out path.

## Test plan
- Reset, then `a`=100, `b`=7, one-cycle `start` -> `busy` high 33 cycles; `quotient`=14, `remainder`=2, `div_by_zero`=0 as `busy` falls.
- `a`=0xFFFFFFFF, `b`=1 -> `quotient`=0xFFFFFFFF, `remainder`=0 after 33 cycles. Then `a`=0xFFFFFFFF, `b`=0xFFFFFFFF -> `quotient`=1, `remainder`=0.
- `a`=5, `b`=0 -> `busy` high 1 cycle; `quotient`=0xFFFFFFFF, `remainder`=5, `div_by_zero`=1. Next, `a`=9, `b`=3 -> `div_by_zero` clears; `quotient`=3, `remainder`=0.
- `a`=3, `b`=10 -> `busy` high 1 cycle; `quotient`=0, `remainder`=3. Repeat with `a`=0, `b`=0 -> `div_by_zero`=1, `remainder`=0.
- Launch 1000/3, pulse `start` with `a`=8, `b`=2 at cycle 10 of CALC -> ignored; result `quotient`=333, `remainder`=1 at cycle 33. Outputs hold the prior result until then.
- Launch 1000/3, assert `reset` at cycle 15 -> `busy`=0 and all outputs 0 immediately. Then 50/8 -> `quotient`=6, `remainder`=2.
